// File: rtl/retire_checker.sv
// Retirement scoreboard: queues expected writeback/flag results and checks them
// in order against retired instructions, with error counting, first-failure capture and a stall watchdog.
module retire_checker #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  parameter int ERR_W   = 16,
  parameter int SEQ_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic              exp_chk_reg,
  input  logic              exp_chk_flags,
  input  logic [REG_AW-1:0] exp_idx,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [3:0]        exp_flags,
  input  logic              obs_valid,
  input  logic              obs_wr,
  input  logic [REG_AW-1:0] obs_idx,
  input  logic [DATA_W-1:0] obs_data,
  input  logic [3:0]        obs_flags,
  input  logic              finish,
  output logic [ERR_W-1:0]  err_count,
  output logic              fail_valid,
  output logic [SEQ_W-1:0]  fail_seq,
  output logic [1:0]        fail_code,
  output logic              timeout,
  output logic              done,
  output logic              pass
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef struct packed {
    logic              chk_reg;
    logic              chk_flags;
    logic [REG_AW-1:0] idx;
    logic [DATA_W-1:0] data;
    logic [3:0]        flags;
  } exp_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  exp_t               r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [WD_W-1:0]    r_wd;
  logic [SEQ_W-1:0]   r_seq;
  logic [ERR_W-1:0]   r_err_count, w_err_nxt;
  logic               r_fail_valid, r_timeout, r_done, r_pass, r_exp_ready;
  logic [SEQ_W-1:0]   r_fail_seq;
  logic [1:0]         r_fail_code, w_code;

  exp_t w_head, w_push_ent;
  logic w_active, w_empty, w_push, w_retire, w_pop;
  logic w_reg_mis, w_flag_mis, w_stall, w_wd_fire, w_err;
  logic w_done_nxt, w_pass_nxt, w_ready_nxt;

  assign w_active   = (r_state != S_DONE);
  assign w_empty    = (r_count == '0);
  assign w_push     = exp_valid && r_exp_ready;
  assign w_retire   = obs_valid && w_active;
  assign w_pop      = w_retire && !w_empty;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_push_ent = '{chk_reg: exp_chk_reg, chk_flags: exp_chk_flags,
                        idx: exp_idx, data: exp_data, flags: exp_flags};

  // Obs_wr without chk_reg is legal: flag-only entries model CMP-style instructions.
  assign w_reg_mis  = w_head.chk_reg &&
                      (!obs_wr || obs_idx != w_head.idx || obs_data != w_head.data);
  assign w_flag_mis = w_head.chk_flags && (obs_flags != w_head.flags);

  assign w_stall    = (r_state == S_RUN || r_state == S_DRAIN) && !w_empty && !obs_valid;
  assign w_wd_fire  = w_stall && (r_wd == WD_W'(TIMEOUT - 1));
  assign w_err      = (w_retire && (w_empty || w_reg_mis || w_flag_mis)) || w_wd_fire;

  always_comb begin
    w_code = 2'b00;
    if (w_retire) begin
      if (w_empty)        w_code = 2'b11;
      else if (w_reg_mis) w_code = 2'b01;
      else                w_code = 2'b10;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT_W'(1);
  end

  assign w_err_nxt = (w_err && !(&r_err_count)) ? r_err_count + ERR_W'(1) : r_err_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_push) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_wd_fire)   w_state_nxt = S_DONE;
        else if (finish) w_state_nxt = w_empty ? S_DONE : S_DRAIN;
      end
      S_DRAIN: if (w_wd_fire || w_empty) w_state_nxt = S_DONE;
      default: w_state_nxt = S_DONE;
    endcase
  end

  always_comb begin
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_pass_nxt  = w_done_nxt && (w_err_nxt == '0);
    w_ready_nxt = (w_count_nxt != CNT_W'(DEPTH)) && !w_done_nxt;
  end

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= w_push_ent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_wd         <= '0;
      r_seq        <= '0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_seq   <= '0;
      r_fail_code  <= 2'b00;
      r_timeout    <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_exp_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_err_count <= w_err_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_exp_ready <= w_ready_nxt;
      if (w_push)   r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_retire) r_seq    <= r_seq + SEQ_W'(1);
      if (!w_stall)       r_wd <= '0;
      else if (!w_wd_fire) r_wd <= r_wd + WD_W'(1);
      if (w_wd_fire) r_timeout <= 1'b1;
      if (w_err && !r_fail_valid) begin
        r_fail_valid <= 1'b1;
        r_fail_seq   <= r_seq;
        r_fail_code  <= w_code;
      end
    end
  end

  assign exp_ready  = r_exp_ready;
  assign err_count  = r_err_count;
  assign fail_valid = r_fail_valid;
  assign fail_seq   = r_fail_seq;
  assign fail_code  = r_fail_code;
  assign timeout    = r_timeout;
  assign done       = r_done;
  assign pass       = r_pass;
endmodule

// File: tb/tb_retire_checker.sv
// Directed bench for retire_checker: hand-computed expectations checked with immediate assertions.
module tb_retire_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exp_valid = 1'b0, exp_ready;
  logic        exp_chk_reg = 1'b0, exp_chk_flags = 1'b0;
  logic [3:0]  exp_idx = '0;
  logic [31:0] exp_data = '0;
  logic [3:0]  exp_flags = '0;
  logic        obs_valid = 1'b0, obs_wr = 1'b0;
  logic [3:0]  obs_idx = '0;
  logic [31:0] obs_data = '0;
  logic [3:0]  obs_flags = '0;
  logic        finish = 1'b0;
  logic [15:0] err_count;
  logic        fail_valid;
  logic [15:0] fail_seq;
  logic [1:0]  fail_code;
  logic        timeout, done, pass;

  int n_vec = 0;
  int n_err = 0;

  retire_checker dut (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_chk_reg(exp_chk_reg), .exp_chk_flags(exp_chk_flags),
    .exp_idx(exp_idx), .exp_data(exp_data), .exp_flags(exp_flags),
    .obs_valid(obs_valid), .obs_wr(obs_wr), .obs_idx(obs_idx),
    .obs_data(obs_data), .obs_flags(obs_flags), .finish(finish),
    .err_count(err_count), .fail_valid(fail_valid), .fail_seq(fail_seq),
    .fail_code(fail_code), .timeout(timeout), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".err_count"},  32'(err_count),  0);
    chk({tag, ".fail_valid"}, 32'(fail_valid), 0);
    chk({tag, ".fail_seq"},   32'(fail_seq),   0);
    chk({tag, ".fail_code"},  32'(fail_code),  0);
    chk({tag, ".timeout"},    32'(timeout),    0);
    chk({tag, ".done"},       32'(done),       0);
    chk({tag, ".pass"},       32'(pass),       0);
    chk({tag, ".exp_ready"},  32'(exp_ready),  1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_exp(input logic cr, input logic cf, input logic [3:0] idx,
                         input logic [31:0] data, input logic [3:0] fl);
    exp_valid = 1'b1; exp_chk_reg = cr; exp_chk_flags = cf;
    exp_idx = idx; exp_data = data; exp_flags = fl;
  endtask

  task automatic set_obs(input logic wr, input logic [3:0] idx,
                         input logic [31:0] data, input logic [3:0] fl);
    obs_valid = 1'b1; obs_wr = wr; obs_idx = idx; obs_data = data; obs_flags = fl;
  endtask

  task automatic push(input logic cr, input logic cf, input logic [3:0] idx,
                      input logic [31:0] data, input logic [3:0] fl);
    set_exp(cr, cf, idx, data, fl);
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic retire(input logic wr, input logic [3:0] idx,
                        input logic [31:0] data, input logic [3:0] fl);
    set_obs(wr, idx, data, fl);
    tick();
    obs_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_reset_vals("reset");

    // Clean run: three register writes and two flag-only entries
    push(1, 0, 4'd0, 32'd2,  4'b0000);
    push(1, 0, 4'd1, 32'd10, 4'b0000);
    push(1, 0, 4'd2, 32'd11, 4'b0000);
    push(0, 1, 4'd0, 32'd0,  4'b1000);
    push(0, 1, 4'd0, 32'd0,  4'b0100);
    retire(1, 4'd0, 32'd2,  4'b0011); idle(7);
    retire(1, 4'd1, 32'd10, 4'b0000); idle(7);
    retire(1, 4'd2, 32'd11, 4'b1111); idle(7);
    retire(0, 4'd0, 32'd0,  4'b1000); idle(7);
    chk("clean.not_done", 32'(done), 0);
    retire(0, 4'd0, 32'd0,  4'b0100); idle(7);
    do_finish();
    chk("clean.err_count", 32'(err_count), 0);
    chk("clean.done",      32'(done),      1);
    chk("clean.pass",      32'(pass),      1);
    chk("clean.ready_done", 32'(exp_ready), 0);
    retire(1, 4'd9, 32'd99, 4'b0000);
    chk("clean.done_hold_err",  32'(err_count), 0);
    chk("clean.done_hold_pass", 32'(pass),      1);

    // Register data mismatch on first retirement
    do_reset();
    push(1, 0, 4'd1, 32'd10, 4'b0000);
    retire(1, 4'd1, 32'd9, 4'b0000);
    chk("regmis.err_count",  32'(err_count),  1);
    chk("regmis.fail_valid", 32'(fail_valid), 1);
    chk("regmis.fail_code",  32'(fail_code),  1);
    chk("regmis.fail_seq",   32'(fail_seq),   0);
    do_finish();
    chk("regmis.done", 32'(done), 1);
    chk("regmis.pass", 32'(pass), 0);

    // Flag mismatch on the second retirement; wr=1 on flag-only entry is fine
    do_reset();
    push(1, 0, 4'd3, 32'd33, 4'b0000);
    push(0, 1, 4'd0, 32'd0,  4'b0100);
    retire(1, 4'd3, 32'd33, 4'b0000);
    chk("flagmis.clean_first", 32'(err_count), 0);
    retire(1, 4'd7, 32'd1234, 4'b1000);
    chk("flagmis.err_count", 32'(err_count), 1);
    chk("flagmis.fail_code", 32'(fail_code), 2);
    chk("flagmis.fail_seq",  32'(fail_seq),  1);

    // Full FIFO, dropped push, simultaneous push+pop, in-order drain
    do_reset();
    for (int i = 0; i < 16; i++) push(1, 0, 4'(i), 32'(100 + i), 4'b0000);
    chk("full.ready0", 32'(exp_ready), 0);
    push(1, 0, 4'd5, 32'd999, 4'b0000);
    chk("full.still_full", 32'(exp_ready), 0);
    retire(1, 4'd0, 32'd100, 4'b0000);
    chk("full.slot_freed", 32'(exp_ready), 1);
    set_exp(1, 0, 4'd0, 32'd116, 4'b0000);
    set_obs(1, 4'd1, 32'd101, 4'b0000);
    tick();
    exp_valid = 1'b0; obs_valid = 1'b0;
    chk("full.pushpop_ready", 32'(exp_ready), 1);
    push(1, 0, 4'd1, 32'd117, 4'b0000);
    chk("full.refilled", 32'(exp_ready), 0);
    for (int i = 2; i < 18; i++) retire(1, 4'(i), 32'(100 + i), 4'b0000);
    chk("full.drain_err", 32'(err_count), 0);
    chk("full.drain_ready", 32'(exp_ready), 1);
    retire(1, 4'd0, 32'd0, 4'b0000);
    chk("full.empty_after_drain", 32'(fail_code), 3);

    // Unexpected retire, then later error keeps the first record
    do_reset();
    retire(1, 4'd0, 32'd0, 4'b0000);
    chk("unexp.err_count",  32'(err_count),  1);
    chk("unexp.fail_valid", 32'(fail_valid), 1);
    chk("unexp.fail_code",  32'(fail_code),  3);
    chk("unexp.fail_seq",   32'(fail_seq),   0);
    push(1, 0, 4'd5, 32'd7, 4'b0000);
    retire(1, 4'd5, 32'd7, 4'b0000);
    push(1, 0, 4'd5, 32'd7, 4'b0000);
    retire(1, 4'd5, 32'd8, 4'b0000);
    chk("unexp2.err_count", 32'(err_count), 2);
    chk("unexp2.fail_code", 32'(fail_code), 3);
    chk("unexp2.fail_seq",  32'(fail_seq),  0);

    // Watchdog: fires on the 64th stall cycle after the push
    do_reset();
    push(1, 0, 4'd0, 32'd1, 4'b0000);
    idle(63);
    chk("wd.not_yet", 32'(timeout), 0);
    idle(1);
    chk("wd.timeout",   32'(timeout),   1);
    chk("wd.done",      32'(done),      1);
    chk("wd.pass",      32'(pass),      0);
    chk("wd.err_count", 32'(err_count), 1);
    chk("wd.fail_code", 32'(fail_code), 0);
    chk("wd.fail_valid", 32'(fail_valid), 1);
    retire(1, 4'd0, 32'd1, 4'b0000);
    chk("wd.hold_err", 32'(err_count), 1);

    // Async reset in DRAIN clears outputs and FIFO contents
    do_reset();
    push(1, 0, 4'd1, 32'd11, 4'b0000);
    push(1, 0, 4'd2, 32'd12, 4'b0000);
    retire(1, 4'd1, 32'd77, 4'b0000);
    do_finish();
    chk("drain.err_count", 32'(err_count), 1);
    chk("drain.not_done",  32'(done),      0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick();
    rst = 1'b0;
    push(1, 0, 4'd2, 32'd22, 4'b0000);
    retire(1, 4'd2, 32'd22, 4'b0000);
    chk("postrst.err_count", 32'(err_count), 0);
    do_finish();
    chk("postrst.pass", 32'(pass), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
